// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
`ifndef PIPE_CTRL_DEFINES
`define PIPE_CTRL_DEFINES
`define RstEnable 1'b1
`define Stop      1'b1
`endif

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    STEP = 2'd2
  } state_t;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0020;

endpackage

// File: rtl/pipe_ctrl_sync_edge.sv
// Two-flop synchroniser for the raw step key followed by a rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic d;

  // Bring the key into the clock domain and keep a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign rise = s2 & ~d;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merge, exception flush, single-step debug and stall counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          STAGES     = 6,
  parameter int          CNT_W      = 32,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              flush_req,
  input  logic              step_mode,
  input  logic              enter,
  input  logic              cnt_clr,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic              step_hold,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              enter_rise;
  logic [STAGES-1:0] req_stall;
  logic              count_en;

  sync_edge u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (enter),
    .rise     (enter_rise)
  );

  // A stage stalls whenever it or any later stage requests a stall
  always_comb begin
    req_stall = '0;
    for (int k = 0; k < STAGES; k++) begin
      req_stall[k] = |(stallreq >> k);
    end
  end

  // Same-cycle stall/flush decode; HOLD freezes everything, flush beats stall requests
  always_comb begin
    stall  = '0;
    flush  = 1'b0;
    new_pc = 32'h0;
    if (rst != `RstEnable) begin
      if (state == HOLD) begin
        stall = '1;
      end else if (flush_req) begin
        flush  = 1'b1;
        new_pc = EXC_VECTOR;
      end else begin
        stall = req_stall;
      end
    end
  end

  assign step_hold = (state == HOLD) && (rst != `RstEnable);
  assign count_en  = (state != HOLD) && !flush && (req_stall != '0);

  // Single-step FSM: HOLD waits for a synchronised key edge, STEP lasts one cycle
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= step_mode ? HOLD : RUN;
        HOLD:    begin
          if (!step_mode)      state <= RUN;
          else if (enter_rise) state <= STEP;
          else                 state <= HOLD;
        end
        STEP:    state <= step_mode ? HOLD : RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating stall-cycle counter; clear wins over increment
  always_ff @(posedge clk) begin
    if (rst == `RstEnable) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (count_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors with hand-computed responses.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  stallreq;
  logic        flush_req;
  logic        step_mode;
  logic        enter;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        step_hold;
  logic [31:0] stall_cnt;
  logic [5:0]  stall_s;
  logic        flush_s;
  logic [31:0] new_pc_s;
  logic        step_hold_s;
  logic [1:0]  stall_cnt_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        hold;
    logic [31:0] cnt;
    logic [1:0]  scnt;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .stallreq  (stallreq),
    .flush_req (flush_req),
    .step_mode (step_mode),
    .enter     (enter),
    .cnt_clr   (cnt_clr),
    .stall     (stall),
    .flush     (flush),
    .new_pc    (new_pc),
    .step_hold (step_hold),
    .stall_cnt (stall_cnt)
  );

  // Narrow-counter copy so saturation is reached in a few cycles
  pipe_ctrl #(.CNT_W(2)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .stallreq  (stallreq),
    .flush_req (flush_req),
    .step_mode (step_mode),
    .enter     (enter),
    .cnt_clr   (cnt_clr),
    .stall     (stall_s),
    .flush     (flush_s),
    .new_pc    (new_pc_s),
    .step_hold (step_hold_s),
    .stall_cnt (stall_cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, actual, required);
    end
  endtask

  // One vector per cycle: drive just after the edge, queue the expected response
  task automatic applyStimulus(input string n, input logic r, input logic [5:0] sq,
                               input logic fr, input logic sm, input logic en, input logic clr,
                               input logic [5:0] es, input logic ef, input logic eh,
                               input logic [31:0] ec, input logic [1:0] esc);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = r;
    stallreq  = sq;
    flush_req = fr;
    step_mode = sm;
    enter     = en;
    cnt_clr   = clr;
    e.name  = n;
    e.stall = es;
    e.flush = ef;
    e.pc    = ef ? 32'h0000_0020 : 32'h0;
    e.hold  = eh;
    e.cnt   = ec;
    e.scnt  = esc;
    sb.push_back(e);
  endtask

  // Monitor: compare the presented outputs mid-cycle against the oldest queued expectation
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput(e.name, "stall",     {26'd0, stall},       {26'd0, e.stall});
      checkOutput(e.name, "flush",     {31'd0, flush},       {31'd0, e.flush});
      checkOutput(e.name, "new_pc",    new_pc,               e.pc);
      checkOutput(e.name, "step_hold", {31'd0, step_hold},   {31'd0, e.hold});
      checkOutput(e.name, "stall_cnt", stall_cnt,            e.cnt);
      checkOutput(e.name, "small_cnt", {30'd0, stall_cnt_s}, {30'd0, e.scnt});
    end
  end

  initial begin
    rst       = 1'b1;
    stallreq  = '0;
    flush_req = 1'b0;
    step_mode = 1'b0;
    enter     = 1'b0;
    cnt_clr   = 1'b0;
    $display("[TB] pipe_ctrl directed run");

    //            name        rst sreq   fr sm en clr  stall  fl hd cnt sc
    applyStimulus("rst0",      1, 6'h10, 0, 0, 0, 0,  6'h00, 0, 0, 0, 0);
    applyStimulus("run1",      0, 6'h10, 0, 0, 0, 0,  6'h1f, 0, 0, 0, 0);
    applyStimulus("run2",      0, 6'h10, 0, 0, 0, 0,  6'h1f, 0, 0, 1, 1);
    applyStimulus("run3",      0, 6'h10, 0, 0, 0, 0,  6'h1f, 0, 0, 2, 2);
    applyStimulus("merge",     0, 6'h14, 0, 0, 0, 0,  6'h1f, 0, 0, 3, 3);
    applyStimulus("flush",     0, 6'h08, 1, 0, 0, 0,  6'h00, 1, 0, 4, 3);
    applyStimulus("idle",      0, 6'h00, 0, 0, 0, 0,  6'h00, 0, 0, 4, 3);
    applyStimulus("smset",     0, 6'h00, 0, 1, 0, 0,  6'h00, 0, 0, 4, 3);
    applyStimulus("hold",      0, 6'h00, 0, 1, 0, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("press",     0, 6'h01, 0, 1, 1, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("sync1",     0, 6'h00, 0, 1, 1, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("rise",      0, 6'h00, 0, 1, 1, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("step",      0, 6'h00, 0, 1, 1, 0,  6'h00, 0, 0, 4, 3);
    applyStimulus("rehold",    0, 6'h00, 0, 1, 1, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("release",   0, 6'h00, 0, 1, 0, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("hflush0",   0, 6'h00, 1, 1, 1, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("hflush1",   0, 6'h00, 1, 1, 1, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("hflush2",   0, 6'h00, 1, 1, 1, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("stepflush", 0, 6'h08, 1, 1, 1, 0,  6'h00, 1, 0, 4, 3);
    applyStimulus("backhold",  0, 6'h08, 0, 0, 1, 0,  6'h3f, 0, 1, 4, 3);
    applyStimulus("runagain",  0, 6'h02, 0, 0, 1, 0,  6'h03, 0, 0, 4, 3);
    applyStimulus("clr",       0, 6'h02, 0, 0, 1, 1,  6'h03, 0, 0, 5, 3);
    applyStimulus("afterclr",  0, 6'h20, 0, 1, 0, 0,  6'h3f, 0, 0, 0, 0);
    applyStimulus("hold2",     0, 6'h00, 0, 1, 1, 0,  6'h3f, 0, 1, 1, 1);
    applyStimulus("bounce",    0, 6'h00, 0, 1, 0, 0,  6'h3f, 0, 1, 1, 1);
    applyStimulus("rise2",     0, 6'h00, 0, 1, 1, 0,  6'h3f, 0, 1, 1, 1);
    applyStimulus("rststep",   1, 6'h04, 0, 1, 0, 0,  6'h00, 0, 0, 1, 1);
    applyStimulus("postrst",   0, 6'h04, 0, 1, 0, 0,  6'h07, 0, 0, 0, 0);
    applyStimulus("noreplay1", 0, 6'h00, 0, 1, 0, 0,  6'h3f, 0, 1, 1, 1);
    applyStimulus("noreplay2", 0, 6'h00, 0, 1, 0, 0,  6'h3f, 0, 1, 1, 1);
    applyStimulus("leave",     0, 6'h00, 0, 0, 0, 0,  6'h3f, 0, 1, 1, 1);
    applyStimulus("runend",    0, 6'h00, 0, 0, 0, 0,  6'h00, 0, 0, 1, 1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain actual=%0d required=0 pending", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the OpenMIPS core: merges per-stage stall requests into the per-stage `stall` vector, handles exception flush with a fixed handler vector, and adds a single-step debug mode in which the pipeline advances one cycle per press of the external `enter` key. It sits beside the pipeline registers and drives their stall and flush controls. It also keeps a saturating stall-cycle performance counter.

## Interface
- `STAGES`, 6, number of pipeline control points: bit0 = pc, 1 = if, 2 = id, 3 = ex, 4 = mem, 5 = wb.
- `CNT_W`, 32, width of the stall-cycle counter.
- `EXC_VECTOR`, 32'h0000_0020, address driven on `new_pc` during a flush.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq`  in  STAGES  bit k = stage k requests a stall this cycle.
- `flush_req`  in  1  exception flush request from the mem stage.
- `step_mode`  in  1  level; 1 selects single-step mode.
- `enter`  in  1  raw, asynchronous step key; 1 = pressed.
- `cnt_clr`  in  1  synchronous clear of `stall_cnt`.
- `stall`  out  STAGES  per-stage stall, same-cycle combinational.
- `flush`  out  1  flush all pipeline registers this cycle.
- `new_pc`  out  32  PC to load when `flush`=1; 0 otherwise.
- `step_hold`  out  1  1 while frozen waiting for a key press (state HOLD).
- `stall_cnt`  out  CNT_W  stall-cycle count.

## Operation
- Request merge: k = highest index with `stallreq[k]`=1; `req_stall` = (1<<(k+1))-1, i.e. bits k..0 set. No request gives `req_stall` = 0. Stage 4 alone gives 6'b011111; stages 2 and 4 together also give 6'b011111.
- FSM states are RUN, HOLD and STEP.
  - RUN: if `step_mode`=1, go to HOLD; else stay in RUN.
  - HOLD: if `step_mode`=0, go to RUN. Else if `enter_rise`, go to STEP. Else stay in HOLD.
  - STEP: always leaves after one cycle. If `step_mode`=1, go to HOLD; else go to RUN.
- Outputs by state:
  - HOLD: `stall` = all ones, `flush` = 0. A pending `flush_req` is ignored; it persists because mem is frozen.
  - RUN or STEP with `flush_req`=1: `flush` = 1, `stall` = 0, `new_pc` = EXC_VECTOR. Flush has priority over stall requests.
  - RUN or STEP otherwise: `stall` = `req_stall`, `flush` = 0, `new_pc` = 0.
- Key synchroniser: `enter` passes through two flops (s1, s2) and then a delay flop d. `enter_rise` = s2 & ~d. All three flops reset to 0. Key bounce is not filtered; every synchronised rising edge counts as a step.
- Counter:
  - `stall_cnt` increments by 1 on every cycle where the state is not HOLD, `flush`=0 and `req_stall` != 0.
  - It saturates at all ones.
  - `cnt_clr`=1 loads 0 and takes priority over the increment.
- Reset: state = RUN, sync flops = 0, `stall_cnt` = 0. During reset, force `stall` = 0, `flush` = 0, `new_pc` = 0 and `step_hold` = 0. A reset in HOLD or STEP returns to RUN at the next edge.

## Timing
- `stall`, `flush` and `new_pc` are combinational from the current inputs and the registered state, with zero latency. This is required for correct pipeline freeze.
- `step_mode` takes effect at the next rising edge.
- `enter` 0→1 while in HOLD: s1 captures it at edge 1 and s2 at edge 2. `enter_rise` is high during the following cycle, and the state becomes STEP at edge 3. Exactly one advance cycle follows, then the state returns to HOLD.
- Holding `enter` high produces only one step; the next step needs a release followed by a new press.
- An `enter` rise while in RUN or STEP is discarded.
- `stall_cnt` updates one edge after the counted cycle.

## Structure
- `pipe_ctrl_pkg` holds:
  - the state enum (RUN=2'd0, HOLD=2'd1, STEP=2'd2);
  - stage index constants (STG_PC..STG_WB);
  - the default EXC_VECTOR.
- The `RstEnable`/`Stop` defines keep their existing header values.
- One sub-module, `sync_edge`, contains the two-flop synchroniser plus rising-edge detector and outputs `enter_rise`.
- The priority encoder and mask generation stay inline in `pipe_ctrl`.

## Test plan
- Run mode: `stallreq`=6'b010000 for 3 cycles → `stall`=6'b011111 on each of those cycles, `stall_cnt` goes 0→3. With `stallreq`=6'b010100 → `stall`=6'b011111.
- `flush_req`=1 together with `stallreq`=6'b001000 in RUN → `flush`=1, `stall`=0, `new_pc`=32'h20, `stall_cnt` unchanged.
- Step sequence: `step_mode`=1, wait 1 cycle → `step_hold`=1, `stall`=6'b111111. Pulse `enter` high for 5 cycles → exactly one STEP cycle with `stall`=0, starting 3 edges after the rise, then HOLD again.
- In HOLD, `flush_req`=1 → `flush`=0, `stall`=all ones. After a step press → `flush`=1 in the STEP cycle.
- Force `stall_cnt` to 32'hFFFF_FFFE, apply 3 stall cycles → stays at 32'hFFFF_FFFF. Then `cnt_clr`=1 together with a stall → 0.
- Assert `rst` while in STEP with `stallreq`≠0 → all outputs 0 that cycle, state RUN afterwards. A pending key rise is not replayed.
